// File: rtl/sort_pkg.sv
// Shared types for the bubble sort master: FSM state encoding and read response codes.
package sort_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    CMP,
    WR_LO,
    WR_HI,
    NEXT,
    DONE
  } sort_state_e;

  localparam int RESP_OKAY = 0;

endpackage

// File: rtl/mem_master_port.sv
// Request/acknowledge front end for the memory AR/R and AW/W channels.
// A single-cycle rd_req/wr_req launches a transaction; the ack pulses when it completes.
module mem_master_port
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rd_req,
  input  logic [ADDR_WDTH-1:0] rd_addr,
  output logic                 rd_ack,
  output logic [DATA_WDTH-1:0] rd_data,
  output logic                 rd_err,
  input  logic                 wr_req,
  input  logic [ADDR_WDTH-1:0] wr_addr,
  input  logic [DATA_WDTH-1:0] wr_data,
  output logic                 wr_ack,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic [DATA_WDTH-1:0] r_data,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data
);

  logic                 ar_valid_q, r_ready_q, aw_valid_q, w_valid_q;
  logic                 aw_done_q, w_done_q;
  logic [ADDR_WDTH-1:0] ar_address_q, aw_address_q;
  logic [DATA_WDTH-1:0] w_data_q;
  logic                 ar_hs, r_hs, aw_hs, w_hs;

  assign ar_hs = ar_valid_q & ar_ready;
  assign r_hs  = r_valid & r_ready_q;
  assign aw_hs = aw_valid_q & aw_ready;
  assign w_hs  = w_valid_q & w_ready;

  assign rd_ack  = r_hs;
  assign rd_data = r_data;
  assign rd_err  = (r_resp != RESP_WDTH'(RESP_OKAY));
  // A write finishes once both halves are in, whichever order they arrived.
  assign wr_ack  = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      ar_address_q <= '0;
      aw_address_q <= '0;
      w_data_q     <= '0;
    end else begin
      if (ar_hs) begin
        ar_valid_q <= 1'b0;
        r_ready_q  <= 1'b1;
      end
      if (r_hs) r_ready_q <= 1'b0;
      if (rd_req) begin
        ar_valid_q   <= 1'b1;
        ar_address_q <= rd_addr;
      end

      if (aw_hs) aw_valid_q <= 1'b0;
      if (w_hs)  w_valid_q  <= 1'b0;
      if (wr_ack) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_q <= 1'b1;
        if (w_hs)  w_done_q  <= 1'b1;
      end
      if (wr_req) begin
        aw_valid_q   <= 1'b1;
        w_valid_q    <= 1'b1;
        aw_address_q <= wr_addr;
        w_data_q     <= wr_data;
      end
    end
  end

  assign ar_valid   = ar_valid_q;
  assign ar_address = ar_address_q;
  assign r_ready    = r_ready_q;
  assign aw_valid   = aw_valid_q;
  assign aw_address = aw_address_q;
  assign w_valid    = w_valid_q;
  assign w_data     = w_data_q;

endmodule

// File: rtl/bubble_sort_master.sv
// In-place bubble sort of memory words 0..LAST_ADDR, one transaction at a time,
// with early exit on a swap-free pass and abort on a read error.
module bubble_sort_master
  import sort_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1,
  parameter int LAST_ADDR = 2**ADDR_WDTH - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [RESP_WDTH-1:0] r_resp,
  input  logic [DATA_WDTH-1:0] r_data,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data
);

  sort_state_e          state_q, state_d;
  logic [ADDR_WDTH-1:0] idx_q, idx_d, limit_q, limit_d, idx_p1;
  logic [DATA_WDTH-1:0] carry_q, carry_d, rd_b_q, rd_b_d;
  logic                 swapped_q, swapped_d, first_q, first_d, err_q, err_d;

  logic                 rd_req, rd_ack, rd_err, wr_req, wr_ack;
  logic [ADDR_WDTH-1:0] rd_addr, wr_addr;
  logic [DATA_WDTH-1:0] rd_data, wr_data;

  mem_master_port #(
    .ADDR_WDTH(ADDR_WDTH),
    .DATA_WDTH(DATA_WDTH),
    .RESP_WDTH(RESP_WDTH)
  ) u_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_ack    (rd_ack),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .ar_valid  (ar_valid),
    .ar_ready  (ar_ready),
    .ar_address(ar_address),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_resp    (r_resp),
    .r_data    (r_data),
    .aw_valid  (aw_valid),
    .aw_ready  (aw_ready),
    .aw_address(aw_address),
    .w_valid   (w_valid),
    .w_ready   (w_ready),
    .w_data    (w_data)
  );

  assign idx_p1 = idx_q + ADDR_WDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      limit_q   <= '0;
      carry_q   <= '0;
      rd_b_q    <= '0;
      swapped_q <= 1'b0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      carry_q   <= carry_d;
      rd_b_q    <= rd_b_d;
      swapped_q <= swapped_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    carry_d   = carry_q;
    rd_b_d    = rd_b_q;
    swapped_d = swapped_q;
    first_d   = first_q;
    err_d     = err_q;
    rd_req    = 1'b0;
    rd_addr   = idx_p1;
    wr_req    = 1'b0;
    wr_addr   = idx_q;
    wr_data   = rd_b_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (LAST_ADDR == 0) begin
            state_d = DONE;
          end else begin
            idx_d     = '0;
            limit_d   = ADDR_WDTH'(LAST_ADDR);
            swapped_d = 1'b0;
            first_d   = 1'b1;
            rd_req    = 1'b1;
            rd_addr   = '0;
            state_d   = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (ar_valid && ar_ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rd_ack) begin
          if (rd_err) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else if (first_q) begin
            // Pass start: the word at idx seeds carry, then fetch idx+1.
            carry_d = rd_data;
            first_d = 1'b0;
            rd_req  = 1'b1;
            rd_addr = idx_p1;
            state_d = RD_ADDR;
          end else begin
            rd_b_d  = rd_data;
            state_d = CMP;
          end
        end
      end
      CMP: begin
        if (carry_q > rd_b_q) begin
          wr_req    = 1'b1;
          wr_addr   = idx_q;
          wr_data   = rd_b_q;
          swapped_d = 1'b1;
          state_d   = WR_LO;
        end else begin
          carry_d = rd_b_q;
          state_d = NEXT;
        end
      end
      WR_LO: begin
        if (wr_ack) begin
          wr_req  = 1'b1;
          wr_addr = idx_p1;
          wr_data = carry_q;
          state_d = WR_HI;
        end
      end
      WR_HI: begin
        if (wr_ack) state_d = NEXT;
      end
      NEXT: begin
        if (idx_p1 < limit_q) begin
          idx_d   = idx_p1;
          rd_req  = 1'b1;
          rd_addr = idx_p1 + ADDR_WDTH'(1);
          state_d = RD_ADDR;
        end else if (!swapped_q || limit_q == ADDR_WDTH'(1)) begin
          state_d = DONE;
        end else begin
          limit_d   = limit_q - ADDR_WDTH'(1);
          idx_d     = '0;
          swapped_d = 1'b0;
          first_d   = 1'b1;
          rd_req    = 1'b1;
          rd_addr   = '0;
          state_d   = RD_ADDR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule
